// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame
// on the device clock, ACK check and timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  state_t          state_q;
  logic [8:0]      shift_q;
  logic [3:0]      edge_q;
  logic [IW-1:0]   inh_q;
  logic [TW-1:0]   to_q;
  logic            clk_dl_q;
  logic            dat_dl_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_fall_d;
  logic running_d;
  logic timeout_d;

  assign clk_fall_d = clk_prev_q & ~clk_s2_q;
  assign running_d  = (state_q == S_SEND) ||
                      (state_q == S_ACK)  ||
                      (state_q == S_WAIT);
  assign timeout_d  = running_d && (to_q == TO_LAST);

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DAT;
      dat_s2_q   <= dat_s1_q;
    end
  end

  // Transfer sequencer with registered pin drives and status pulses.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      edge_q   <= '0;
      inh_q    <= '0;
      to_q     <= '0;
      clk_dl_q <= 1'b0;
      dat_dl_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (timeout_d) begin
        state_q  <= S_IDLE;
        clk_dl_q <= 1'b0;
        dat_dl_q <= 1'b0;
        busy_q   <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        if (running_d) to_q <= to_q + TW'(1);
        unique case (state_q)
          S_IDLE: begin
            clk_dl_q <= 1'b0;
            dat_dl_q <= 1'b0;
            busy_q   <= 1'b0;
            if (start) begin
              shift_q  <= {~^tx_byte, tx_byte};
              inh_q    <= '0;
              clk_dl_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_q == INH_LAST) begin
              dat_dl_q <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              inh_q <= inh_q + IW'(1);
            end
          end
          S_REQ: begin
            clk_dl_q <= 1'b0;
            edge_q   <= '0;
            to_q     <= '0;
            state_q  <= S_SEND;
          end
          S_SEND: begin
            if (clk_fall_d) begin
              edge_q <= edge_q + 4'd1;
              if (edge_q == 4'd9) begin
                dat_dl_q <= 1'b0;
                state_q  <= S_ACK;
              end else begin
                dat_dl_q <= ~shift_q[0];
                shift_q  <= shift_q >> 1;
              end
            end
          end
          S_ACK: begin
            if (clk_fall_d) begin
              if (dat_s2_q) begin
                clk_dl_q <= 1'b0;
                dat_dl_q <= 1'b0;
                busy_q   <= 1'b0;
                err_q    <= 1'b1;
                state_q  <= S_IDLE;
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (clk_s2_q && dat_s2_q) begin
              clk_dl_q <= 1'b0;
              dat_dl_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_clk_drive_low = clk_dl_q;
  assign ps2_dat_drive_low = dat_dl_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = err_q;

endmodule
